// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the shared UART TX arbiter.
// The arbiter uses the slave modport; the requesters and uart_tx side use master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [NUM_REQ*8-1:0] i_req_data;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_tx_en;
  logic [7:0]           o_tx_data;
  logic                 i_tx_busy;
  logic                 o_active;
  logic                 o_start_fault;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_busy,
    output o_req_ready, o_grant, o_tx_en, o_tx_data, o_active, o_start_fault
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_busy,
    input  o_req_ready, o_grant, o_tx_en, o_tx_data, o_active, o_start_fault
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NUM_REQ
// byte-stream requesters; sequences the tx_en / busy-rise / busy-fall handshake.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_SEND       = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_ptr;
  logic               r_tx_en;
  logic [7:0]         r_tx_data;
  logic               r_last;
  logic [CW-1:0]      r_cnt;
  logic               r_fault;

  logic               w_sel_found;
  logic [IW-1:0]      w_sel_idx;
  logic               w_owner_valid;
  logic [7:0]         w_owner_data;
  logic               w_owner_last;
  logic               w_accept;
  logic               w_timeout;
  logic               w_byte_done;
  logic [IW-1:0]      w_next_ptr;

  // Scan downward from the farthest slot so the nearest valid requester at or
  // after the pointer is the last (winning) assignment.
  always_comb begin : sel_blk
    int idx;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.i_req_valid[idx]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(idx);
      end
    end
  end

  assign w_owner_valid = bus.i_req_valid[r_owner];
  assign w_owner_data  = bus.i_req_data[r_owner*8 +: 8];
  assign w_owner_last  = bus.i_req_last[r_owner];
  assign w_accept      = (r_state == S_SEND) && w_owner_valid && !bus.i_tx_busy;
  assign w_timeout     = (r_state == S_WAIT_START) && !bus.i_tx_busy &&
                         (r_cnt == CW'(START_TIMEOUT - 1));
  assign w_byte_done   = w_timeout || ((r_state == S_WAIT_DONE) && !bus.i_tx_busy);
  assign w_next_ptr    = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign bus.o_req_ready[gi] = w_accept && (r_owner == IW'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_found) begin
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
            r_owner <= w_sel_idx;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            r_tx_data <= w_owner_data;
            r_tx_en   <= 1'b1;
            r_last    <= w_owner_last;
            r_cnt     <= '0;
            r_state   <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (bus.i_tx_busy)  r_state <= S_WAIT_DONE;
          else if (w_timeout) r_fault <= 1'b1;
          else                r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase
      // A timed-out byte is treated as sent and follows the normal release path.
      if (w_byte_done) begin
        if (r_last) begin
          r_ptr   <= w_next_ptr;
          r_grant <= '0;
          r_state <= S_IDLE;
        end else begin
          r_state <= S_SEND;
        end
      end
    end
  end

  assign bus.o_grant       = r_grant;
  assign bus.o_tx_en       = r_tx_en;
  assign bus.o_tx_data     = r_tx_data;
  assign bus.o_active      = (r_state != S_IDLE);
  assign bus.o_start_fault = r_fault;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester packets, a uart_tx busy
// model, a table of round-robin scenarios and hand-written corner sequences.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] order;
  } row_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] src_q [N][$];
  logic [N-1:0] en;
  logic [N-1:0] accept;
  logic [1:0] tx_own_q [$];
  logic [7:0] tx_dat_q [$];
  bit         uart_on;
  int         busy_cnt;
  logic       prev_tx_en;
  row_t       tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < N; k++) if (g[k]) r = 2'(k);
    return r;
  endfunction

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (en[k] && src_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [N*8-1:0] d;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < N; k++) begin
      if (en[k] && src_q[k].size() > 0) begin
        v[k]       = 1'b1;
        d[8*k +: 8] = src_q[k][0][7:0];
        l[k]       = src_q[k][0][8];
      end
    end
    bus.i_req_valid = v;
    bus.i_req_data  = d;
    bus.i_req_last  = l;
  endtask

  task automatic refresh();
    drive_inputs();
    #1;
    accept = bus.i_req_valid & bus.o_req_ready;
  endtask

  task automatic load(input int k, input logic [7:0] b, input logic last);
    src_q[k].push_back({last, b});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (accept[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    check("grant_onehot0", 32'($onehot0(bus.o_grant)), 32'd1);
    if (bus.o_tx_en) begin
      check("tx_en_gap", 32'(prev_tx_en), 32'd0);
      tx_own_q.push_back(oh2idx(bus.o_grant));
      tx_dat_q.push_back(bus.o_tx_data);
      if (uart_on) busy_cnt = BUSY_LEN;
    end
    prev_tx_en    = bus.o_tx_en;
    bus.i_tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    refresh();
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((pending() || bus.o_active) && guard < 3000) begin
      step();
      guard++;
    end
    if (guard >= 3000) bound_fail({name, "_drain"});
  endtask

  task automatic wait_tx(input string name, input int cnt);
    int guard;
    guard = 0;
    while (tx_own_q.size() < cnt && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) bound_fail({name, "_wait_tx"});
  endtask

  task automatic clear_log();
    tx_own_q.delete();
    tx_dat_q.delete();
  endtask

  // Entry i of the expected log: owner own[2i+:2], byte dat[8i+:8].
  task automatic check_log(input string name, input int n, input logic [15:0] own,
                           input logic [63:0] dat);
    check({name, "_count"}, 32'(tx_own_q.size()), 32'(n));
    for (int i = 0; i < n && i < tx_own_q.size(); i++) begin
      check($sformatf("%s_own%0d", name, i), 32'(tx_own_q[i]), 32'(own[2*i +: 2]));
      check($sformatf("%s_dat%0d", name, i), 32'(tx_dat_q[i]), 32'(dat[8*i +: 8]));
    end
    clear_log();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] eo;
    logic [63:0] ed;

    tbl[0] = '{mask: 4'b0101, n: 2, order: 8'h02};
    tbl[1] = '{mask: 4'b1001, n: 2, order: 8'h03};
    tbl[2] = '{mask: 4'b1111, n: 4, order: 8'h39};
    tbl[3] = '{mask: 4'b0110, n: 2, order: 8'h09};
    tbl[4] = '{mask: 4'b1000, n: 1, order: 8'h03};
    tbl[5] = '{mask: 4'b1001, n: 2, order: 8'h0C};
    tbl[6] = '{mask: 4'b0100, n: 1, order: 8'h02};
    tbl[7] = '{mask: 4'b1001, n: 2, order: 8'h03};

    en = '1; accept = '0; uart_on = 1'b1; busy_cnt = 0; prev_tx_en = 1'b0;
    rst = 1'b1;
    bus.i_tx_busy   = 1'b0;
    bus.i_req_valid = '1;
    bus.i_req_data  = 32'hDEADBEEF;
    bus.i_req_last  = '1;
    #12;
    check("rst_grant", 32'(bus.o_grant), 32'd0);
    check("rst_tx_en", 32'(bus.o_tx_en), 32'd0);
    check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_active", 32'(bus.o_active), 32'd0);
    check("rst_fault", 32'(bus.o_start_fault), 32'd0);
    check("rst_ready", 32'(bus.o_req_ready), 32'd0);
    #6 rst = 1'b0;
    refresh();

    // Contention from reset: req0 then req2, no interleaving; pointer ends at 3.
    load(0, 8'hA0, 0); load(0, 8'hA1, 0); load(0, 8'hA2, 1);
    load(2, 8'hC0, 0); load(2, 8'hC1, 0); load(2, 8'hC2, 1);
    refresh();
    drain("contention");
    check_log("contention", 6, 16'b10_10_10_00_00_00, 64'hC2C1C0A2A1A0);
    load(0, 8'hB0, 1); load(3, 8'hD0, 1);
    refresh();
    drain("ptr3");
    check_log("ptr3", 2, 16'b00_11, 64'hB0D0);

    // Round-robin table: single-byte packets from each requester in the mask.
    for (int r = 0; r < 8; r++) begin
      eo = '0; ed = '0;
      for (int k = 0; k < N; k++)
        if (tbl[r].mask[k]) load(k, 8'(8'h80 + r*16 + k), 1'b1);
      for (int i = 0; i < tbl[r].n; i++) begin
        eo[2*i +: 2] = tbl[r].order[2*i +: 2];
        ed[8*i +: 8] = 8'(8'h80 + r*16 + int'(tbl[r].order[2*i +: 2]));
      end
      refresh();
      drain($sformatf("row%0d", r));
      check_log($sformatf("row%0d", r), tbl[r].n, eo, ed);
    end

    // Single requester with latency checks; pointer moves to 2.
    load(1, 8'h48, 0); load(1, 8'h69, 1);
    refresh();
    step();
    check("single_grant", 32'(bus.o_grant), 32'h2);
    check("single_ready", 32'(bus.o_req_ready), 32'h2);
    step();
    check("single_tx_en", 32'(bus.o_tx_en), 32'd1);
    check("single_tx_data", 32'(bus.o_tx_data), 32'h48);
    drain("single");
    check_log("single", 2, 16'b01_01, 64'h6948);
    check("single_grant_end", 32'(bus.o_grant), 32'd0);
    check("single_active_end", 32'(bus.o_active), 32'd0);
    load(1, 8'hE1, 1); load(2, 8'hE2, 1);
    refresh();
    drain("ptr2");
    check_log("ptr2", 2, 16'b01_10, 64'hE1E2);

    // Stall: owner req0 drops valid mid-packet while req1 waits.
    load(0, 8'h10, 0); load(0, 8'h11, 0); load(0, 8'h12, 1); load(1, 8'h20, 1);
    refresh();
    wait_tx("stall", 1);
    en[0] = 1'b0;
    refresh();
    for (int i = 0; i < 50; i++) step();
    check("stall_no_tx", 32'(tx_own_q.size()), 32'd1);
    check("stall_grant", 32'(bus.o_grant), 32'h1);
    en[0] = 1'b1;
    refresh();
    drain("stall");
    check_log("stall", 4, 16'b01_00_00_00, 64'h20121110);

    // Start timeout: busy never rises; fault after START_TIMEOUT cycles, sticky.
    uart_on = 1'b0;
    load(2, 8'h31, 0); load(2, 8'h32, 1);
    refresh();
    wait_tx("timeout", 1);
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i == TO - 1) check("timeout_early", 32'(bus.o_start_fault), 32'd0);
    end
    check("timeout_fault", 32'(bus.o_start_fault), 32'd1);
    drain("timeout");
    check_log("timeout", 2, 16'b10_10, 64'h3231);
    check("timeout_grant_end", 32'(bus.o_grant), 32'd0);
    uart_on = 1'b1;
    load(3, 8'h40, 1);
    refresh();
    drain("after_timeout");
    check_log("after_timeout", 1, 16'b11, 64'h40);
    check("fault_sticky", 32'(bus.o_start_fault), 32'd1);

    // Asynchronous reset in WAIT_DONE, asserted between clock edges.
    load(1, 8'h50, 0); load(1, 8'h51, 1);
    refresh();
    wait_tx("areset", 1);
    for (int i = 0; i < 3; i++) step();
    check("areset_pre_active", 32'(bus.o_active), 32'd1);
    check("areset_pre_data", 32'(bus.o_tx_data), 32'h50);
    #2 rst = 1'b1;
    #1;
    check("areset_tx_en", 32'(bus.o_tx_en), 32'd0);
    check("areset_grant", 32'(bus.o_grant), 32'd0);
    check("areset_active", 32'(bus.o_active), 32'd0);
    check("areset_ready", 32'(bus.o_req_ready), 32'd0);
    check("areset_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("areset_fault", 32'(bus.o_start_fault), 32'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    clear_log();
    accept = '0;
    #7 rst = 1'b0;
    load(3, 8'h60, 1); load(0, 8'h61, 1);
    refresh();
    drain("post_reset");
    check_log("post_reset", 2, 16'b11_00, 64'h6061);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
